// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared constants and width helpers for the FIFO read-side controller.
package fifo_rd_ctrl_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 12;
    localparam int unsigned MAX_RD_LATENCY = 3;
    localparam int unsigned MAX_BUF_DEPTH  = 4;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) r = r + 1;
        return r;
    endfunction

    // Pointer width for a circular buffer of the given depth (at least 1 bit).
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth <= 1) ? 1 : clog2(depth);
    endfunction

    // Width able to hold the values 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_skid_buf.sv
// Circular output buffer: push/pop with registered head data and valid flag.
module rd_skid_buf
    import fifo_rd_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic                              clk,
    input  logic                              Reset,
    input  logic                              push,
    input  logic [DATA_WIDTH-1:0]             push_data,
    input  logic                              pop,
    output logic [cnt_width(BUF_DEPTH)-1:0]   count,
    output logic                              out_valid,
    output logic [DATA_WIDTH-1:0]             out_data
);

    localparam int unsigned PTR_W = ptr_width(BUF_DEPTH);
    localparam int unsigned CNT_W = cnt_width(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_nxt;

    // Explicit wrap so non-power-of-two depths stay correct.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (!Reset) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) mem[PTR_W'(i)] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
        end
    end

    assign out_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side FIFO controller: credit-checked pops, latency tag pipe, and a
// skid buffer re-presenting FIFO words on a valid/ready stream.
module fifo_rd_ctrl
    import fifo_rd_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic                  FIFO_empty,
    input  logic [DATA_WIDTH-1:0] FIFO_data_out,
    output logic                  read_enable,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int unsigned CNT_W  = cnt_width(BUF_DEPTH);
    localparam int unsigned CRED_W = cnt_width(BUF_DEPTH + MAX_RD_LATENCY);

    logic [RD_LATENCY-1:0] tag;
    logic [CNT_W-1:0]      buf_count;
    logic [CRED_W-1:0]     inflight;
    logic [CRED_W-1:0]     credit_used;
    logic                  push;
    logic                  pop;

    assign pop  = out_valid & out_ready;
    assign push = tag[RD_LATENCY-1];

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CRED_W'(tag[i]);
        end
    end

    // The slot freed by this cycle's pop is reusable, which sustains one word
    // per cycle; with out_ready low this reduces to buf_count + inflight.
    assign credit_used = CRED_W'(buf_count) + inflight - CRED_W'(pop);
    assign read_enable = Reset & Enable & ~FIFO_empty
                       & (credit_used < CRED_W'(BUF_DEPTH));

    assign busy = (inflight != '0) | (buf_count != '0);

    // Tag pipe: the oldest bit marks FIFO_data_out as valid this cycle.
    generate
        if (RD_LATENCY == 1) begin : g_tag1
            always_ff @(posedge clk) begin
                if (!Reset) tag <= '0;
                else        tag <= read_enable;
            end
        end else begin : g_tagn
            always_ff @(posedge clk) begin
                if (!Reset) tag <= '0;
                else        tag <= {tag[RD_LATENCY-2:0], read_enable};
            end
        end
    endgenerate

    rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_skid (
        .clk       (clk),
        .Reset     (Reset),
        .push      (push),
        .push_data (FIFO_data_out),
        .pop       (pop),
        .count     (buf_count),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl driving a behavioural 1-cycle-latency FIFO.
module tb_fifo_rd_ctrl;

    localparam int unsigned DW = 12;

    logic          clk = 1'b0;
    logic          Reset = 1'b0;
    logic          Enable = 1'b1;
    logic          FIFO_empty = 1'b1;
    logic [DW-1:0] FIFO_data_out = '0;
    logic          read_enable;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int popped = 0;
    int delivered = 0;
    int re_count = 0;

    always #5 clk = ~clk;

    fifo_rd_ctrl #(.DATA_WIDTH(DW), .RD_LATENCY(1), .BUF_DEPTH(2)) dut (
        .clk           (clk),
        .Reset         (Reset),
        .Enable        (Enable),
        .FIFO_empty    (FIFO_empty),
        .FIFO_data_out (FIFO_data_out),
        .read_enable   (read_enable),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy)
    );

    // Behavioural FIFO; a reset loses every word popped but not yet delivered.
    always @(posedge clk) begin
        if (read_enable) begin
            re_count++;
            if (fq.size() != 0) begin
                FIFO_data_out <= fq.pop_front();
                popped++;
            end
        end
        if (wr_en) fq.push_back(wr_data);
        FIFO_empty <= (fq.size() == 0);
        if (!Reset) begin
            while (popped > delivered) begin
                void'(exp_q.pop_front());
                popped--;
            end
        end
    end

    // Monitor: handshakes against the scoreboard, issue safety, hold protocol.
    logic          hold_prev = 1'b0;
    logic [DW-1:0] hold_data = '0;
    always @(negedge clk) begin
        logic [DW-1:0] e;
        vectors++;
        if (Reset && read_enable && FIFO_empty) begin
            miscompares++;
            $display("FAIL re_when_empty: read_enable=1 with FIFO_empty=1 at %0t", $time);
        end else if (!Reset && read_enable) begin
            miscompares++;
            $display("FAIL re_in_reset: read_enable=1 while Reset=0 at %0t", $time);
        end
        if (Reset) begin
            if (hold_prev) begin
                vectors++;
                if (!out_valid || out_data !== hold_data) begin
                    miscompares++;
                    $display("FAIL hold: valid=%0b data=%03h, required valid=1 data=%03h",
                             out_valid, out_data, hold_data);
                end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL spurious_out: got %03h, no word expected", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        miscompares++;
                        $display("FAIL out_data: got %03h expected %03h", out_data, e);
                    end
                    delivered++;
                end
            end
            hold_prev = out_valid && !out_ready;
            hold_data = out_data;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        step();
        wr_en = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || !FIFO_empty) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(exp_q.size()), 0);
        chk({name, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        int first_re, first_v, last_v, nv, re0, d0;

        // 1: reset held with the FIFO non-empty
        step();
        wr(12'h111);
        wr(12'h222);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("t1_fifo_nonempty", int'(FIFO_empty), 0);
            chk("t1_read_enable", int'(read_enable), 0);
            chk("t1_out_valid", int'(out_valid), 0);
            chk("t1_busy", int'(busy), 0);
            chk("t1_out_data", int'(out_data), 0);
        end
        step();
        Reset = 1'b1;
        out_ready = 1'b1;
        drain("t1_drain");

        // 2: four words, free-flowing consumer
        step();
        first_re = -1; first_v = -1; last_v = -1; nv = 0;
        fork
            begin
                for (int k = 1; k <= 4; k++) wr(DW'(k));
            end
            begin
                for (int c = 0; c < 16; c++) begin
                    @(negedge clk);
                    if (read_enable && first_re < 0) first_re = c;
                    if (out_valid && out_ready) begin
                        if (first_v < 0) first_v = c;
                        last_v = c;
                        nv++;
                    end
                end
            end
        join
        chk("t2_latency_edges", first_v - (first_re + 1), 1);
        chk("t2_words", nv, 4);
        chk("t2_consecutive", last_v - first_v, 3);
        chk("t2_fifo_empty", int'(FIFO_empty), 1);
        drain("t2_drain");

        // 3: backpressure stops issue after two credits
        step();
        out_ready = 1'b0;
        re0 = re_count;
        for (int k = 0; k < 6; k++) wr(DW'(12'h0A0 + k));
        repeat (4) step();
        @(negedge clk);
        chk("t3_pops", re_count - re0, 2);
        chk("t3_out_valid", int'(out_valid), 1);
        chk("t3_out_data", int'(out_data), 'h0A0);
        chk("t3_fifo_words", int'(fq.size()), 4);
        step();
        out_ready = 1'b1;
        drain("t3_drain");

        // 4: single word
        step();
        re0 = re_count;
        wr(12'hFFF);
        repeat (5) step();
        chk("t4_pulses", re_count - re0, 1);
        drain("t4_drain");

        // 5: Enable dropped mid-stream
        step();
        Enable = 1'b0;
        re0 = re_count;
        wr(12'h050);
        wr(12'h051);
        wr(12'h052);
        step();
        @(negedge clk);
        chk("t5_no_issue_disabled", re_count - re0, 0);
        step();
        Enable = 1'b1;
        @(negedge clk);
        chk("t5_issue", int'(read_enable), 1);
        step();
        Enable = 1'b0;
        d0 = delivered;
        @(negedge clk);
        chk("t5_stop_immediate", int'(read_enable), 0);
        repeat (4) step();
        @(negedge clk);
        chk("t5_inflight_delivered", delivered - d0, 1);
        chk("t5_fifo_words", int'(fq.size()), 2);
        chk("t5_idle", int'(busy), 0);
        step();
        Enable = 1'b1;
        drain("t5_drain");

        // 6: reset while a read is in flight
        step();
        wr(12'h066);
        @(negedge clk);
        chk("t6_issue", int'(read_enable), 1);
        step();
        Reset = 1'b0;
        d0 = delivered;
        step();
        Reset = 1'b1;
        @(negedge clk);
        chk("t6_out_valid", int'(out_valid), 0);
        chk("t6_busy", int'(busy), 0);
        repeat (4) step();
        @(negedge clk);
        chk("t6_discarded", delivered - d0, 0);
        chk("t6_scoreboard", int'(exp_q.size()), 0);
        chk("t6_idle", int'(busy), 0);

        // Random writes, random backpressure, occasional disable
        step();
        for (int c = 0; c < 400; c++) begin
            Enable    = ($urandom_range(9) != 0);
            out_ready = $urandom_range(1);
            wr_en     = (fq.size() < 10) && ($urandom_range(1) == 1);
            if (wr_en) begin
                wr_data = DW'($urandom);
                exp_q.push_back(wr_data);
            end
            step();
        end
        wr_en = 1'b0;
        Enable = 1'b1;
        out_ready = 1'b1;
        drain("rand_drain");
        chk("rand_count", delivered, popped);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
